down_counter: RTL
=================

DOWN_COUNTER -- requirements
Module: down_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 8, counter and load-value width in bits.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1  load request, sampled only in IDLE.
REQ-005 SHALL have port start_value  input  WIDTH  count to load on accepted start.
REQ-006 SHALL have port auto_reload  input  1  reload-and-continue select, sampled in DONE.
REQ-007 SHALL have port pause  input  1  hold count while in RUN.
REQ-008 SHALL have port stop  input  1  abort request, effective in RUN and DONE.
REQ-009 SHALL have port ready  output  1  high only in IDLE; start is accepted only when high.
REQ-010 SHALL have port busy  output  1  high in RUN and DONE.
REQ-011 SHALL have port count  output  WIDTH  current registered count value.
REQ-012 SHALL have port done  output  1  high exactly while in DONE (one-cycle terminal pulse).

Function
REQ-013 SHALL implement a three-state FSM: IDLE, RUN, DONE; all outputs registered or decoded from state only.
REQ-014 SHALL, in IDLE with start=1 and start_value!=0, load count=start_value, latch start_value into a reload register, enter RUN at that edge.
REQ-015 SHALL, in IDLE with start=1 and start_value==0, keep count=0, latch reload register=0, enter DONE at that edge.
REQ-016 SHALL, in IDLE with start=0, hold count and state.
REQ-017 SHALL, in RUN with pause=0 and stop=0, decrement count by 1 per cycle, modulo 2^WIDTH arithmetic never used (count never wraps below 0).
REQ-018 SHALL, in RUN when count==1 and pause=0 and stop=0, set count=0 and enter DONE at that edge.
REQ-019 SHALL, in RUN with pause=1 and stop=0, hold count and remain in RUN.
REQ-020 SHALL, in DONE with stop=0 and auto_reload=1 and reload register!=0, load count=reload register and enter RUN.
REQ-021 SHALL, in DONE with stop=0 and (auto_reload=0 or reload register==0), hold count=0 and enter IDLE.
REQ-022 SHALL, in RUN or DONE with stop=1, set count=0 and enter IDLE at that edge; stop has priority over pause and auto_reload; done not asserted as a result of stop.
REQ-023 SHALL ignore start outside IDLE and stop/pause in IDLE.
REQ-024 SHALL give latency: start accepted at edge k with value V>=1 and no pause -> done high in the cycle after edge k+V; auto-reload period V+1 cycles.
REQ-025 SHALL accept a new start in the first IDLE cycle after DONE (back-to-back operation, no dead cycle beyond DONE).
REQ-026 SHALL support start_value = 2^WIDTH-1 without overflow (count 255 -> 0 in 255 unpaused cycles for WIDTH=8).

Reset
REQ-027 SHALL, on reset=1, immediately (without clk) force state IDLE, count=0, reload register=0, done=0, busy=0, ready=1.
REQ-028 SHALL, on reset asserted mid-RUN or in DONE, abandon the operation with no done pulse; first edge after reset release behaves as IDLE.

Verification
REQ-029 SHALL verify: reset, start=1 start_value=3 auto_reload=0 one cycle -> count 3,2,1,0 on successive edges, done high one cycle with count 0, then ready=1.
REQ-030 SHALL verify: start_value=2 auto_reload=1 held -> count 2,1,0,2,1,0,...; done pulses every 3 cycles; busy stays 1.
REQ-031 SHALL verify: start_value=5, pause=1 for 4 cycles after count reaches 3 -> count holds 3 for 4 cycles; done arrives 4 cycles later than unpaused.
REQ-032 SHALL verify: start_value=10, stop=1 when count=6 -> next edge count=0, ready=1, done never asserted; start during RUN ignored.
REQ-033 SHALL verify: start_value=0 -> done high the cycle after acceptance, count remains 0, return to IDLE even with auto_reload=1.
REQ-034 SHALL verify: reset asserted asynchronously between clock edges during RUN at count=7 -> count=0, busy=0, ready=1 before next edge; start_value=255 run completes in 255 cycles.

Source files
------------

// File: rtl/down_counter.sv
// Loadable down-counter with IDLE/RUN/DONE control, pause, abort and optional
// auto-reload; status outputs are decoded from the state register.
module down_counter #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] start_value,
   input  logic             auto_reload,
   input  logic             pause,
   input  logic             stop,
   output logic             ready,
   output logic             busy,
   output logic [WIDTH-1:0] count,
   output logic             done
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]       state;
   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] reload_q;

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         count_q  <= '0;
         reload_q <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  count_q  <= start_value;
                  reload_q <= start_value;
                  state    <= (start_value != '0) ? RUN : DONE;
               end
            end
            RUN: begin
               if (stop) begin
                  count_q <= '0;
                  state   <= IDLE;
               end else if (!pause) begin
                  // Count is never zero in RUN; reaching one ends the run.
                  if (count_q <= WIDTH'(1)) begin
                     count_q <= '0;
                     state   <= DONE;
                  end else begin
                     count_q <= count_q - WIDTH'(1);
                  end
               end
            end
            DONE: begin
               if (!stop && auto_reload && (reload_q != '0)) begin
                  count_q <= reload_q;
                  state   <= RUN;
               end else begin
                  count_q <= '0;
                  state   <= IDLE;
               end
            end
            default: begin
               // Unused encoding recovers to a clean idle.
               count_q <= '0;
               state   <= IDLE;
            end
         endcase
      end
   end

   assign ready = (state == IDLE);
   assign busy  = (state == RUN) || (state == DONE);
   assign done  = (state == DONE);
   assign count = count_q;

endmodule
